// File: rtl/axil_ram_pkg.sv
// Shared constants for the AXI4-Lite RAM: word-address width derivation and response codes.
// No logic; imported by the RAM core and the AXI-Lite front end.
// No flow control of its own.
package axil_ram_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Byte address minus the lane-select bits gives the word index width.
  function automatic int valid_addr_width(input int addr_width, input int strb_width);
    return addr_width - $clog2(strb_width);
  endfunction

endpackage

// File: rtl/axil_ram_mem.sv
// Byte-lane-enabled synchronous RAM: one write port, one registered read port.
// Latency: write lands at the edge we is sampled; rdata valid one cycle after re.
// No backpressure: rdata holds its value while re is low.
module axil_ram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (we && wstrb[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read samples the array before this edge's write lands, so a same-cycle
  // read of the written word returns the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axil_ram.sv
// AXI4-Lite slave RAM with independent write and read handshake controllers; always responds OKAY.
// Latency: one cycle from accept to bvalid/rvalid; at most one transaction per channel every two cycles.
// Backpressure: a held bvalid/rvalid blocks further accepts on that channel until bready/rready.
module axil_ram
  import axil_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int VALID_ADDR_WIDTH = valid_addr_width(ADDR_WIDTH, STRB_WIDTH);
  localparam int LANE_BITS        = ADDR_WIDTH - VALID_ADDR_WIDTH;

  logic                        wr_acc;
  logic                        rd_acc;
  logic [VALID_ADDR_WIDTH-1:0] wr_word;
  logic [VALID_ADDR_WIDTH-1:0] rd_word;
  logic                        unused_ok;

  assign wr_word = s_axil_awaddr[ADDR_WIDTH-1 -: VALID_ADDR_WIDTH];
  assign rd_word = s_axil_araddr[ADDR_WIDTH-1 -: VALID_ADDR_WIDTH];

  assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                       s_axil_awaddr[LANE_BITS-1:0], s_axil_araddr[LANE_BITS-1:0]};

  // The ready pulse from the previous accept blocks an immediate repeat, so a
  // master holding valids high gets a new transaction every other cycle.
  assign wr_acc = s_axil_awvalid && s_axil_wvalid && (!s_axil_bvalid || s_axil_bready)
                  && !s_axil_awready && !s_axil_wready;
  assign rd_acc = s_axil_arvalid && (!s_axil_rvalid || s_axil_rready) && !s_axil_arready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
    end else begin
      s_axil_awready <= wr_acc;
      s_axil_wready  <= wr_acc;
      s_axil_bvalid  <= wr_acc || (s_axil_bvalid && !s_axil_bready);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
    end else begin
      s_axil_arready <= rd_acc;
      s_axil_rvalid  <= rd_acc || (s_axil_rvalid && !s_axil_rready);
    end
  end

  assign s_axil_bresp = RESP_OKAY;
  assign s_axil_rresp = RESP_OKAY;

  axil_ram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (VALID_ADDR_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && !rst),
    .waddr (wr_word),
    .wdata (s_axil_wdata),
    .wstrb (s_axil_wstrb),
    .re    (rd_acc && !rst),
    .raddr (rd_word),
    .rdata (s_axil_rdata)
  );

endmodule

// File: tb/tb_axil_ram.sv
// Directed bench for axil_ram: 8-word RAM, strobes, backpressure, channel independence, reset.
module tb_axil_ram;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  int n_checks = 0;
  int n_fail   = 0;

  axil_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes the write channel is idle and bready=1 on entry.
  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_awready", {31'd0, awready}, 32'd1);
    check("wr_wready",  {31'd0, wready},  32'd1);
    check("wr_bvalid",  {31'd0, bvalid},  32'd1);
    check("wr_bresp",   {30'd0, bresp},   32'd0);
    tick();
  endtask

  // Assumes the read channel is idle and rready=1 on entry.
  task automatic axi_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    araddr = a; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check({tag, "_arready"}, {31'd0, arready}, 32'd1);
    check({tag, "_rvalid"},  {31'd0, rvalid},  32'd1);
    check({tag, "_rresp"},   {30'd0, rresp},   32'd0);
    check({tag, "_rdata"},   rdata,            exp);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    tick();
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_rdata",   rdata,            32'd0);
    check("rst_bresp",   {30'd0, bresp},   32'd0);
    check("rst_rresp",   {30'd0, rresp},   32'd0);
    rst = 1'b0;
    tick();

    // Lane bits ignored: byte addresses 1 and 0 both hit word 0.
    axi_write(5'd1, 32'd2345, 4'hF);
    axi_read(5'd1, 32'd2345, "rd_a1");
    axi_read(5'd0, 32'd2345, "rd_a0");

    axi_write(5'd8, 32'h11223344, 4'hF);
    axi_write(5'd8, 32'hAABBCCDD, 4'b0101);
    axi_read(5'd8, 32'h11BB33DD, "rd_strb");

    // W alone, then AW alone: neither may accept.
    awaddr = 5'd8; wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wonly_awready", {31'd0, awready}, 32'd0);
      check("wonly_wready",  {31'd0, wready},  32'd0);
      check("wonly_bvalid",  {31'd0, bvalid},  32'd0);
    end
    wvalid = 1'b0; awvalid = 1'b1;
    tick();
    tick();
    check("awonly_bvalid", {31'd0, bvalid}, 32'd0);
    awvalid = 1'b0;
    axi_read(5'd8, 32'h11BB33DD, "rd_nowr");

    // bready low: response held, held valids must not be re-accepted.
    bready = 1'b0;
    awaddr = 5'd12; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    check("bp_awready", {31'd0, awready}, 32'd1);
    check("bp_bvalid",  {31'd0, bvalid},  32'd1);
    wdata = 32'h66;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_bvalid",  {31'd0, bvalid},  32'd1);
      check("bp_hold_awready", {31'd0, awready}, 32'd0);
    end
    // Raising bready with valids still up: old response retires, new write accepted same edge.
    bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp_reacc_awready", {31'd0, awready}, 32'd1);
    check("bp_reacc_bvalid",  {31'd0, bvalid},  32'd1);
    tick();
    check("bp_drop_bvalid", {31'd0, bvalid}, 32'd0);
    axi_read(5'd12, 32'h66, "rd_bp");

    // rready low: read data held while a write to the same word proceeds.
    axi_write(5'd4, 32'd7, 4'hF);
    rready = 1'b0;
    araddr = 5'd4; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("rbp_rvalid", {31'd0, rvalid}, 32'd1);
    check("rbp_rdata",  rdata,           32'd7);
    awaddr = 5'd4; wdata = 32'd9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("rbp_wr_bvalid", {31'd0, bvalid}, 32'd1);
    check("rbp_hold_rvalid", {31'd0, rvalid}, 32'd1);
    check("rbp_hold_rdata",  rdata,           32'd7);
    tick();
    check("rbp_hold2_rdata", rdata, 32'd7);
    rready = 1'b1;
    tick();
    check("rbp_drop_rvalid", {31'd0, rvalid}, 32'd0);
    axi_read(5'd4, 32'd9, "rd_rbp");

    // Same-edge write and read of one word: read returns the old data.
    awaddr = 5'd16; wdata = 32'hA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'd16; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("rw_old_rdata", rdata, 32'd0);
    check("rw_bvalid", {31'd0, bvalid}, 32'd1);
    tick();
    axi_read(5'd16, 32'hA, "rd_rw_new");

    // Reset drops a pending response.
    bready = 1'b0;
    axi_write(5'd20, 32'h1234, 4'hF);
    check("rst_mid_pre_bvalid", {31'd0, bvalid}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_bvalid", {31'd0, bvalid}, 32'd0);
    // A write presented while reset is sampled must not land.
    awaddr = 5'd16; wdata = 32'hDEAD; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("rst_wr_awready", {31'd0, awready}, 32'd0);
    rst = 1'b0; bready = 1'b1;
    tick();
    axi_read(5'd16, 32'hA, "rd_rst_nowr");
    axi_read(5'd20, 32'h1234, "rd_rst_pre");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_ram.md
# axil_ram

AXI4-Lite slave RAM: a single-port-per-channel, word-organised memory behind an AXI4-Lite slave interface with independent write and read paths. It serves as the target memory for AXI-Lite master logic such as write/read handlers and HLS-generated datapaths. It returns OKAY on every transaction and applies byte-lane strobes on writes.

## Interface
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- ADDR_WIDTH, 16, byte-address width.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width.
- Derived constant VALID_ADDR_WIDTH = ADDR_WIDTH - log2(STRB_WIDTH); depth = 2**VALID_ADDR_WIDTH words.

One clock; reset is synchronous and active-high. Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- s_axil_awaddr  in  ADDR_WIDTH  write byte address.
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address accepted.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  STRB_WIDTH  byte enables.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data accepted.
- s_axil_bresp  out  2  constant 2'b00 (OKAY).
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  response accepted by master.
- s_axil_araddr  in  ADDR_WIDTH  read byte address.
- s_axil_arprot  in  3  ignored.
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address accepted.
- s_axil_rdata  out  DATA_WIDTH  registered read data.
- s_axil_rresp  out  2  constant 2'b00 (OKAY).
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data accepted.

## Operation
- Word index = addr[ADDR_WIDTH-1 : ADDR_WIDTH-VALID_ADDR_WIDTH]; low log2(STRB_WIDTH) bits ignored (byte address 1 and 0 hit word 0).
- Write accept condition (evaluated each cycle): awvalid && wvalid && (!bvalid || bready) && !awready && !wready. AW and W are only ever accepted together; either valid alone never accepts.
- On accept: for each i with wstrb[i]=1, byte lane i of the addressed word <= wdata byte i; other lanes unchanged. Next cycle awready=wready=1 (single-cycle pulse) and bvalid=1.
- bvalid holds until sampled with bready=1, then clears unless a new accept occurs in that same cycle.
- Read accept condition: arvalid && (!rvalid || rready) && !arready. On accept: rdata <= mem[word], next cycle arready=1 (one-cycle pulse), rvalid=1.
- rvalid/rdata hold stable until sampled with rready=1.
- Read and write channels fully independent; same-cycle write and read of the same word returns the old data.
- Reset: awready, wready, bvalid, arready, rvalid = 0; rdata = 0. Memory contents not affected by reset; simulation initial contents all zero.
- Reset mid-transaction drops any pending response; no partial write occurs after reset is sampled.

## Timing
- Write: valids sampled high at edge N -> memory updated at edge N; awready, wready, bvalid high in cycle N+1; earliest next accept at edge N+2 (min two cycles per write with bready held 1).
- Read: arvalid sampled at edge N -> rdata/rvalid/arready valid cycle N+1; earliest next accept at edge N+2.
- Masters holding valids high after a response get another transaction every other cycle; the block does not suppress repeats.
- No combinational path from any input to any output.

## Structure
- Shared package: VALID_ADDR_WIDTH derivation and RESP_OKAY = 2'b00.
- One natural sub-module: axil_ram_mem, byte-lane-enabled synchronous RAM (one write port, one registered read port); top level holds only the two handshake controllers.

## Test plan
Use DATA_WIDTH=32, ADDR_WIDTH=5 (8 words), bready=rready=1 unless stated.
- Reset 1 cycle -> all ready/valid outputs 0, bresp=0, rresp=0.
- awaddr=1, wdata=2345, wstrb=4'hF, awvalid=wvalid=1 for one edge -> next cycle awready=wready=bvalid=1, bresp=0; then read araddr=1 -> rvalid=1, rdata=2345.
- Write 32'h11223344 to addr 8, then 32'hAABBCCDD with wstrb=4'b0101 -> read addr 8 returns 32'h11BB33DD.
- wvalid=1, awvalid=0 for 5 cycles -> awready, wready, bvalid stay 0; memory unchanged.
- bready=0 after a write -> bvalid held high, no second accept while valids held; raise bready -> bvalid drops, next write accepted.
- rready=0 with read to addr 4 holding 7 -> rvalid/rdata=7 stable; concurrent write of 9 to addr 4 then re-read -> 9.
